// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES registered
// ripple-carry segments, valid/ready flow control on both sides.
// Ports: Clock, Reset (sync, active high), InValid/InReady,
//   A, B, CarryIn, Sub, OutValid/OutReady, SUM, COUT, OVF, ZERO.
// Macro ADDER_FLAGS_EN builds OVF/ZERO; otherwise both tie to 0.
module pipelined_adder #(
  parameter int WIDTH  = 24,
  parameter int STAGES = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  input  logic             Sub,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             OVF,
  output logic             ZERO
);
  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;

  // Link k carries what stage k consumes.
  logic             v_l [STAGES];
  logic [WIDTH-1:0] a_l [STAGES];
  logic [WIDTH-1:0] b_l [STAGES];
  logic [WIDTH-1:0] s_l [STAGES];
  logic             c_l [STAGES];
`ifdef ADDER_FLAGS_EN
  logic             m_l [STAGES];
  logic [WIDTH-1:0] fin_s;
  logic             fin_c;
  logic             fin_m;
`endif

  logic [STAGES-1:0] v_all;
  logic [STAGES-1:0] adv;

  // Stage k may move if the output is taken or any
  // stage from k to the output holds a bubble.
  always_comb begin
    logic full;
    full = 1'b1;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full   = full & v_all[k];
      adv[k] = OutReady | ~full;
    end
  end

  assign InReady = !Reset && adv[0];
  assign v_l[0]  = InValid && InReady;
  assign a_l[0]  = A;
  assign b_l[0]  = Sub ? ~B : B;
  assign s_l[0]  = '0;
  assign c_l[0]  = CarryIn;
`ifdef ADDER_FLAGS_EN
  assign m_l[0]  = 1'b0;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = (k * CHUNK < WIDTH) ? k * CHUNK : WIDTH;
    localparam int HI =
      (k == STAGES - 1 || (k + 1) * CHUNK > WIDTH) ?
      WIDTH : (k + 1) * CHUNK;

    logic             v_q;
    logic             c_q;
    logic             c_d;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] s_d;
`ifdef ADDER_FLAGS_EN
    logic             m_q;
    logic             m_d;
`endif

    always_comb begin
      logic c;
      c   = c_l[k];
      s_d = s_l[k];
`ifdef ADDER_FLAGS_EN
      m_d = m_l[k];
`endif
      for (int i = LO; i < HI; i++) begin
`ifdef ADDER_FLAGS_EN
        if (i == WIDTH - 1) m_d = c;
`endif
        s_d[i] = a_l[k][i] ^ b_l[k][i] ^ c;
        c = (a_l[k][i] & b_l[k][i]) |
            (c & (a_l[k][i] ^ b_l[k][i]));
      end
      c_d = c;
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
`ifdef ADDER_FLAGS_EN
        m_q <= 1'b0;
`endif
      end else if (adv[k]) begin
        v_q <= v_l[k];
        if (v_l[k]) begin
          s_q <= s_d;
          c_q <= c_d;
`ifdef ADDER_FLAGS_EN
          m_q <= m_d;
`endif
        end
      end
    end

    assign v_all[k] = v_q;

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      always_ff @(posedge Clock) begin
        if (Reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv[k] && v_l[k]) begin
          a_q <= a_l[k];
          b_q <= b_l[k];
        end
      end
      assign v_l[k+1] = v_q;
      assign a_l[k+1] = a_q;
      assign b_l[k+1] = b_q;
      assign s_l[k+1] = s_q;
      assign c_l[k+1] = c_q;
`ifdef ADDER_FLAGS_EN
      assign m_l[k+1] = m_q;
`endif
    end else begin : g_out
      assign OutValid = v_q;
      assign SUM      = s_q;
      assign COUT     = c_q;
`ifdef ADDER_FLAGS_EN
      assign fin_s    = s_d;
      assign fin_c    = c_d;
      assign fin_m    = m_d;
`endif
    end
  end

`ifdef ADDER_FLAGS_EN
  logic ovf_q;
  logic zero_q;

  // Flags are formed from the final segment's result as it
  // is registered, so they move in lockstep with SUM.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (adv[STAGES-1] && v_l[STAGES-1]) begin
      ovf_q  <= fin_m ^ fin_c;
      zero_q <= ~|fin_s;
    end
  end

  assign OVF  = ovf_q;
  assign ZERO = zero_q;
`else
  assign OVF  = 1'b0;
  assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and streamed checks of
// pipelined_adder at STAGES = 1, 3 and 24 (WIDTH = 24).
module tb_pipelined_adder;
  localparam int W = 24;
`ifdef ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, ci, sub, out_ready;
  logic [W-1:0] a, b;
  logic         rdy1, ov1, co1, ovf1, z1;
  logic         rdy3, ov3, co3, ovf3, z3;
  logic         rdy24, ov24, co24, ovf24, z24;
  logic [W-1:0] sum1, sum3, sum24;

  pipelined_adder #(.WIDTH(W), .STAGES(3)) u_s3 (
    .Clock(clk), .Reset(rst), .InValid(in_valid),
    .InReady(rdy3), .A(a), .B(b), .CarryIn(ci),
    .Sub(sub), .OutValid(ov3), .OutReady(out_ready),
    .SUM(sum3), .COUT(co3), .OVF(ovf3), .ZERO(z3));

  pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
    .Clock(clk), .Reset(rst), .InValid(in_valid),
    .InReady(rdy1), .A(a), .B(b), .CarryIn(ci),
    .Sub(sub), .OutValid(ov1), .OutReady(out_ready),
    .SUM(sum1), .COUT(co1), .OVF(ovf1), .ZERO(z1));

  pipelined_adder #(.WIDTH(W), .STAGES(24)) u_s24 (
    .Clock(clk), .Reset(rst), .InValid(in_valid),
    .InReady(rdy24), .A(a), .B(b), .CarryIn(ci),
    .Sub(sub), .OutValid(ov24), .OutReady(out_ready),
    .SUM(sum24), .COUT(co24), .OVF(ovf24), .ZERO(z24));

  int     n_chk = 0;
  int     n_err = 0;
  int     got = 0;
  res_t   sbq[$];
  logic   hold = 1'b0;
  logic [W-1:0] hsum;
  logic   hco;

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] aa,
                                 input logic [W-1:0] bi,
                                 input logic c,
                                 input logic s);
    logic [W:0]   t;
    logic [W-1:0] bb;
    res_t         r;
    bb = s ? ~bi : bi;
    t = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = FLAGS && (aa[W-1] == bb[W-1]) &&
             (t[W-1] != aa[W-1]);
    r.zero = FLAGS && (t[W-1:0] == '0);
    return r;
  endfunction

  // One clock of the STAGES=3 unit against the scoreboard.
  task automatic cycle(output logic acc);
    logic fin, fout, had;
    res_t e;
    @(negedge clk);
    fin  = in_valid && rdy3;
    fout = ov3 && out_ready;
    had  = sbq.size() > 0;
    chk("in_ready", W'(rdy3),
        W'(!rst && (sbq.size() < 3 || out_ready)));
    if (hold) begin
      chk("stall_valid", W'(ov3), W'(1));
      chk("stall_sum", sum3, hsum);
      chk("stall_cout", W'(co3), W'(hco));
    end
    hold = ov3 && !out_ready;
    hsum = sum3;
    hco  = co3;
    if (fout) begin
      if (!had) chk("spurious_out", W'(ov3), W'(0));
      else begin
        e = sbq[0];
        chk("sum", sum3, e.sum);
        chk("cout", W'(co3), W'(e.cout));
        chk("ovf", W'(ovf3), W'(e.ovf));
        chk("zero", W'(z3), W'(e.zero));
      end
    end
    @(posedge clk);
    if (fin) sbq.push_back(model(a, b, ci, sub));
    if (fout && had) begin
      e = sbq.pop_front();
      got++;
    end
    #1;
    acc = fin;
  endtask

  task automatic send(input logic [W-1:0] aa,
                      input logic [W-1:0] bb,
                      input logic c, input logic s);
    logic acc;
    logic done;
    done = 1'b0;
    a = aa; b = bb; ci = c; sub = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      cycle(acc);
      done = acc;
    end
    chk("send_accept", W'(done), W'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sbq.size() > 0; i++)
      cycle(acc);
    chk("drain_empty", W'(sbq.size()), W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    logic acc;
    int   l1, l3, l24, c1, c3, c24, sent;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_inready", W'(rdy3), W'(0));
    chk("rst_valid", W'(ov3), W'(0));
    chk("rst_sum", sum3, W'(0));
    chk("rst_cout", W'(co3), W'(0));
    chk("rst_ovf", W'(ovf3), W'(0));
    chk("rst_zero", W'(z3), W'(0));
    chk("rst_inready_s1", W'(rdy1), W'(0));
    chk("rst_inready_s24", W'(rdy24), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_inready", W'(rdy3), W'(1));
    chk("rel_inready_s1", W'(rdy1), W'(1));
    chk("rel_inready_s24", W'(rdy24), W'(1));

    // Latency of one op through all three depths.
    a = 24'hFFFFFF; b = 24'h000001; ci = 0; sub = 0;
    e = model(a, b, ci, sub);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l1 = -1; l3 = -1; l24 = -1;
    c1 = 0; c3 = 0; c24 = 0;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (ov1) begin
        if (c1 == 0) begin
          l1 = t;
          chk("s1_sum", sum1, e.sum);
          chk("s1_cout", W'(co1), W'(e.cout));
          chk("s1_zero", W'(z1), W'(e.zero));
          chk("s1_ovf", W'(ovf1), W'(e.ovf));
        end
        c1++;
      end
      if (ov3) begin
        if (c3 == 0) begin
          l3 = t;
          chk("s3_sum", sum3, e.sum);
          chk("s3_cout", W'(co3), W'(e.cout));
          chk("s3_zero", W'(z3), W'(e.zero));
          chk("s3_ovf", W'(ovf3), W'(e.ovf));
        end
        c3++;
      end
      if (ov24) begin
        if (c24 == 0) begin
          l24 = t;
          chk("s24_sum", sum24, e.sum);
          chk("s24_cout", W'(co24), W'(e.cout));
          chk("s24_zero", W'(z24), W'(e.zero));
          chk("s24_ovf", W'(ovf24), W'(e.ovf));
        end
        c24++;
      end
      @(posedge clk); #1;
    end
    chk("lat_s1", W'(l1), W'(0));
    chk("lat_s3", W'(l3), W'(2));
    chk("lat_s24", W'(l24), W'(23));
    chk("once_s1", W'(c1), W'(1));
    chk("once_s3", W'(c3), W'(1));
    chk("once_s24", W'(c24), W'(1));

    // Overflow and subtract cases through the scoreboard.
    send(24'h7FFFFF, 24'h000001, 1'b0, 1'b0);
    send(24'd5, 24'd7, 1'b1, 1'b1);
    send(24'd7, 24'd5, 1'b1, 1'b1);
    drain();

    // Random stream with a 1,0,0 consumer pattern.
    got = 0;
    sent = 0;
    a = W'($urandom); b = W'($urandom);
    ci = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      out_ready = (cyc % 3 == 0);
      cycle(acc);
      if (acc) begin
        sent++;
        if (sent < 10) begin
          a = W'($urandom); b = W'($urandom);
          ci = 1'($urandom); sub = 1'($urandom);
        end else in_valid = 1'b0;
      end
    end
    chk("stream_count", W'(got), W'(10));
    drain();

    // Reset with two ops in flight discards both.
    out_ready = 1'b0;
    send(W'($urandom), W'($urandom), 1'b0, 1'b0);
    send(W'($urandom), W'($urandom), 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_inready", W'(rdy3), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    hold = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", W'(ov3), W'(0));
    chk("mid_rst_sum", sum3, W'(0));
    chk("mid_rst_cout", W'(co3), W'(0));
    chk("mid_rst_ovf", W'(ovf3), W'(0));
    chk("mid_rst_zero", W'(z3), W'(0));
    chk("mid_rst_inready_rel", W'(rdy3), W'(1));
    out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) cycle(acc);
    send(24'h123456, 24'h0EDCBA, 1'b0, 1'b0);
    drain();
    chk("post_rst_count", W'(got), W'(1));

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Parametrised, pipelined add/subtract unit that generalises the single-bit full adder to a WIDTH-bit carry chain.
- The chain is split into STAGES registered segments; each segment is a slice of 1-bit full adders.
- Valid/ready handshakes on both sides give one operation per cycle with full backpressure.
- Sits between operand fetch and writeback in the CPU datapath and produces SUM, COUT and optional OVF/ZERO flags.

## Interface
- WIDTH, 24, operand/result width; legal range ≥2.
- STAGES, 3, pipeline segments; legal range 1..WIDTH.
- Segment widths: CHUNK = ceil(WIDTH/STAGES) bits for every segment except the last, which takes the remainder.
- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand set present.
- InReady  output  1  unit accepts operands this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CarryIn  input  1  carry into bit 0.
- Sub  input  1  1 = subtract (B inverted).
- OutValid  output  1  result present.
- OutReady  input  1  consumer takes result this cycle.
- SUM  output  WIDTH  result.
- COUT  output  1  carry out of MSB.
- OVF  output  1  signed overflow.
- ZERO  output  1  SUM == 0.

## Operation
- Arithmetic: result = A + (Sub ? ~B : B) + CarryIn, computed modulo 2^WIDTH.
  - For a plain subtract the caller drives Sub=1, CarryIn=1.
  - COUT is the raw carry, so for subtraction COUT=1 means no borrow.
- Stage k adds bits [k·CHUNK +: chunk_k] using the carry registered by stage k-1.
  - Upper operand bits and Sub are carried forward in delay registers.
  - Lower result bits already computed are carried forward the same way.
- OVF = carry into MSB XOR carry out of MSB. ZERO = ~|SUM. Both are computed in the final stage.
- Each stage holds a valid bit.
  - A stage advances when it is not valid, or when the stage downstream of it advances.
  - The output stage advances when !OutValid or OutReady.
- InReady = !Reset && (stage 0 not valid || stage 0 advances). It is combinational from OutReady through the valid chain.
- Transfer rules:
  - Input is accepted on an edge with InValid && InReady.
  - Output is consumed on an edge with OutValid && OutReady.
- While OutValid && !OutReady, SUM/COUT/OVF/ZERO and OutValid stay stable until consumed.
- Results leave in acceptance order. No result is dropped or duplicated.

## Timing
- Reset, with Reset high at an edge:
  - all stage valid bits clear; OutValid=0, SUM=0, COUT=0, OVF=0, ZERO=0.
  - InReady=0 while Reset is high and 1 in the first cycle after release.
- Latency: an operation accepted at edge n is visible on the outputs after edge n+STAGES-1.
  - STAGES=1 gives a result visible directly after the acceptance edge.
- Throughput: one operation per cycle while OutReady=1.
- Full pipeline (all valid) with OutReady=0: InReady=0, no stage moves.
- Full pipeline with OutReady=1 and InValid=1: emit and accept on the same edge; occupancy is unchanged.
- Bubbles collapse: a stage with a bubble ahead of it moves forward even while the output is stalled.
- Reset mid-operation: all in-flight operations are discarded with no partial output. The next accepted operation follows normal latency.
- Wrap-around: sums ≥ 2^WIDTH wrap and set COUT. No saturation.

## Configuration
- ADDER_FLAGS_EN defined:
  - OVF and ZERO are computed and registered as described above.
- ADDER_FLAGS_EN undefined:
  - OVF and ZERO ports remain but are tied to 0.
  - No MSB-carry tap or zero-detect logic is synthesised.
  - SUM, COUT and the handshake are unaffected.

## Test plan
All scenarios use WIDTH=24, STAGES=3 and ADDER_FLAGS_EN defined unless stated.
- A=0xFFFFFF, B=0x000001, CarryIn=0, Sub=0, OutReady=1 -> SUM=0x000000, COUT=1, ZERO=1, OVF=0; OutValid after edge n+2, for one cycle.
- A=0x7FFFFF, B=0x000001, Sub=0, CarryIn=0 -> SUM=0x800000, OVF=1, COUT=0, ZERO=0.
- A=5, B=7, Sub=1, CarryIn=1 -> SUM=0xFFFFFE, COUT=0, OVF=0. Then A=7, B=5 -> SUM=0x000002, COUT=1.
- Stream of 10 random ops with InValid=1 and OutReady pattern 1,0,0,1,... -> all 10 results match the model, in order.
  - Outputs stay stable while stalled.
  - InReady=0 whenever 3 ops are held and OutReady=0.
- Fill with 2 ops, assert Reset for 1 cycle -> OutValid=0 and all outputs 0 after the edge. The 2 ops never appear. InReady=1 in the first cycle after release.
- Repeat the first scenario with STAGES=1 (SUM valid after edge n) and STAGES=24 (SUM valid after edge n+23).
  - With ADDER_FLAGS_EN undefined, OVF=ZERO=0 throughout while SUM/COUT are unchanged.
